// File: rtl/param_mux_rr.sv
// N-channel registered mux with fixed-select and round-robin modes behind a one-entry output register.
// Optional feature: define PARAM_MUX_RR_PARITY_EN to add the y_par output (XOR of the captured data).
module param_mux_rr #(
  parameter int N = 8,
  parameter int W = 1,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] d,
  input  logic [N-1:0]   in_valid,
  input  logic [SW-1:0]  s,
  input  logic           mode,
  output logic [N-1:0]   in_ready,
`ifdef PARAM_MUX_RR_PARITY_EN
  output logic           y_par,
`endif
  output logic [W-1:0]   y,
  output logic [SW-1:0]  y_ch,
  output logic           y_valid,
  input  logic           y_ready
);

  logic [W-1:0]  y_q, y_d;
  logic [SW-1:0] y_ch_q, y_ch_d;
  logic          y_valid_q, y_valid_d;
  logic [SW-1:0] ptr_q, ptr_d;

  logic          load;
  logic          eligible;
  logic          cap;
  logic [SW-1:0] g;
  logic [SW-1:0] rr_g;
  logic [SW-1:0] idx;
  logic          rr_found;
  logic [W-1:0]  sel_data;

  // Round-robin search: first valid channel starting at ptr; SW-bit add wraps modulo N.
  always_comb begin
    rr_found = 1'b0;
    rr_g     = '0;
    idx      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = ptr_q + SW'(k);
      if (!rr_found && in_valid[idx]) begin
        rr_found = 1'b1;
        rr_g     = idx;
      end
    end
  end

  always_comb begin
    load     = !y_valid_q || y_ready;
    eligible = mode ? rr_found : in_valid[s];
    g        = mode ? rr_g : s;
    cap      = !rst && load && eligible;

    sel_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (g == SW'(i)) sel_data = d[i*W +: W];
    end

    in_ready = '0;
    if (cap) in_ready[g] = 1'b1;

    y_d       = y_q;
    y_ch_d    = y_ch_q;
    y_valid_d = y_valid_q;
    ptr_d     = ptr_q;
    if (load) begin
      y_valid_d = eligible;
      if (eligible) begin
        y_d    = sel_data;
        y_ch_d = g;
        if (mode) ptr_d = g + SW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q       <= '0;
      y_ch_q    <= '0;
      y_valid_q <= 1'b0;
      ptr_q     <= '0;
    end else begin
      y_q       <= y_d;
      y_ch_q    <= y_ch_d;
      y_valid_q <= y_valid_d;
      ptr_q     <= ptr_d;
    end
  end

  assign y       = y_q;
  assign y_ch    = y_ch_q;
  assign y_valid = y_valid_q;

`ifdef PARAM_MUX_RR_PARITY_EN
  logic y_par_q, y_par_d;

  always_comb begin
    y_par_d = y_par_q;
    if (load && eligible) y_par_d = ^sel_data;
  end

  always_ff @(posedge clk) begin
    if (rst) y_par_q <= 1'b0;
    else     y_par_q <= y_par_d;
  end

  assign y_par = y_par_q;
`endif

endmodule

// File: doc/param_mux_rr.md
PARAM_MUX_RR -- requirements
Module: param_mux_rr

Interface
REQ-001 SHALL have parameter N, default 8: number of input channels, a power of two, at least 2.
REQ-002 SHALL have parameter W, default 1: data width per channel.
REQ-003 SHALL have derived parameter SW = clog2(N): select and channel-index width.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port d, input, N*W bits: channel i occupies d[i*W +: W].
REQ-007 SHALL have port in_valid, input, N bits: per-channel data-valid.
REQ-008 SHALL have port s, input, SW bits: channel select, used in fixed mode.
REQ-009 SHALL have port mode, input, 1 bit: 0 = fixed select, 1 = round-robin scan.
REQ-010 SHALL have port in_ready, output, N bits: one-hot pulse marking the channel captured this cycle; all zero when nothing is captured.
REQ-011 SHALL have port y, output, W bits: registered selected data.
REQ-012 SHALL have port y_ch, output, SW bits: index of the channel that produced y.
REQ-013 SHALL have port y_valid, output, 1 bit: y, y_ch are valid.
REQ-014 SHALL have port y_ready, input, 1 bit: downstream accepts y when y_valid and y_ready are both high.

Function
REQ-015 SHALL use a one-entry output register; load = !y_valid || y_ready.
REQ-016 SHALL, in fixed mode, capture when load && in_valid[s]: y <= d[s], y_ch <= s, y_valid <= 1.
REQ-017 SHALL, in round-robin mode, grant g = first i with in_valid[i] searching ptr, ptr+1, ..., ptr+N-1 modulo N; capture d[g] when load and any in_valid is high.
REQ-018 SHALL, after a round-robin grant, update ptr <= (g+1) mod N with wrap N-1 -> 0; ptr SHALL NOT change on cycles with no grant or in fixed mode.
REQ-019 SHALL drive in_ready combinationally as one-hot(captured channel) in the capture cycle only.
REQ-020 SHALL have a latency of exactly 1 cycle from capture edge to y_valid/y visible.
REQ-021 SHALL, when load is high and no eligible valid input exists, clear y_valid and hold y and y_ch at their last values.
REQ-022 SHALL, while y_valid && !y_ready, hold y, y_ch, y_valid stable and keep in_ready all zero (back-pressure).
REQ-023 SHALL sustain one transfer per cycle under continuous y_ready=1 with an eligible input present.
REQ-024 SHALL sample mode and s only at a load cycle; a change in mode or s takes effect at the next load cycle, and ptr is retained across mode changes.

Reset
REQ-025 SHALL, when rst is high at a clock edge, set y=0, y_ch=0, y_valid=0, ptr=0; in_ready SHALL be all zero while rst is high.
REQ-026 SHALL discard any held unaccepted output on reset mid-operation, without a transfer.

Configuration
REQ-027 SHALL, when macro PARAM_MUX_RR_PARITY_EN is defined, add output y_par (1 bit) = XOR of captured data, registered with y and reset to 0.
REQ-028 SHALL, when PARAM_MUX_RR_PARITY_EN is undefined, omit the y_par port with all other behaviour identical.

Verification (N=8, W=4)
REQ-029 SHALL cover fixed mode: d channel 5 = 4'hA, in_valid=8'hFF, s=5, y_ready=1 -> next cycle y=4'hA, y_ch=5, y_valid=1, in_ready=8'b0010_0000 in the capture cycle.
REQ-030 SHALL cover round-robin fairness: mode=1, in_valid=8'b1000_0101, y_ready=1 -> y_ch sequence 0,2,7,0,2,7; ptr wraps after 7.
REQ-031 SHALL cover back-pressure: y_valid=1 with y_ready=0 for 3 cycles -> y, y_ch held and in_ready=0; when y_ready=1, the next channel is captured the following cycle.
REQ-032 SHALL cover empty input: in_valid=0, y_ready=1 -> y_valid=0 next cycle and y unchanged.
REQ-033 SHALL cover reset mid-stream: rst=1 during stall with y_valid=1 -> y=0, y_ch=0, y_valid=0; first grant after reset is the lowest valid channel.
REQ-034 SHALL, when PARAM_MUX_RR_PARITY_EN is defined, check that capturing 4'b1011 gives y_par=1.
